// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset default and queue entry type for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fq_entry_t;

  // Sequential fetch address; wraps modulo 2^64.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-request, queue-head and redirect signals of the fetch front end.
// Handshakes: an imem request fires on imem_req_out & imem_ready_in and holds its address until
// accepted or redirected; the head is consumed on valid_out & ready_in; no valid depends on a ready.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic            imem_req_out;
  logic [XLEN-1:0] imem_addr_out;
  logic            imem_ready_in;
  logic            imem_valid_in;
  logic [ILEN-1:0] imem_data_in;
  logic            valid_out;
  logic [XLEN-1:0] pc_out;
  logic [ILEN-1:0] instr_out;
  logic            ready_in;
  logic            pred_taken_in;
  logic [XLEN-1:0] pred_target_in;
  logic            redirect_in;
  logic [XLEN-1:0] redirect_pc_in;
  logic [7:0]      flush_cnt_out;

  modport master (
    output imem_req_out, imem_addr_out, valid_out, pc_out, instr_out, flush_cnt_out,
    input  imem_ready_in, imem_valid_in, imem_data_in, ready_in,
    input  pred_taken_in, pred_target_in, redirect_in, redirect_pc_in
  );

  modport slave (
    input  imem_req_out, imem_addr_out, valid_out, pc_out, instr_out, flush_cnt_out,
    output imem_ready_in, imem_valid_in, imem_data_in, ready_in,
    output pred_taken_in, pred_target_in, redirect_in, redirect_pc_in
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous circular FIFO with clear; pop data reads zero while empty.
module fetch_queue_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign do_pop     = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = bump(wr_ptr_q);
      if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC generation, imem request issue, in-order instruction queue and redirect/kill handling.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2
) (
  input logic          clk_in,
  input logic          rst_in,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   kill_q, kill_d;
  logic [7:0]      flush_cnt_q, flush_cnt_d;

  logic [OW-1:0]   outst, outst_next;
  logic [XLEN-1:0] tag_pc;
  logic            tag_full, tag_empty;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;
  fq_entry_t       push_entry, head;

  logic req, fire, resp, drop, consume, pred_flush, flush, q_push, q_pop;

  // A queue slot is reserved for every in-flight request, so a response never finds the queue full.
  assign req        = !rst_in && !q_full && !tag_full && ((int'(q_count) + int'(outst)) < DEPTH);
  assign fire       = req && bus.imem_ready_in;
  assign resp       = bus.imem_valid_in && !tag_empty;
  assign drop       = resp && (kill_q != '0);
  assign consume    = !q_empty && bus.ready_in;
  assign pred_flush = consume && bus.pred_taken_in && !bus.redirect_in;
  assign flush      = bus.redirect_in || pred_flush;
  assign q_push     = resp && !drop && !flush;
  assign q_pop      = consume && !flush;
  assign outst_next = outst + OW'(fire) - OW'(resp);
  assign push_entry = '{pc: tag_pc, instr: bus.imem_data_in};

  always_comb begin
    kill_d = kill_q;
    // Everything still in flight after a flush (including a same-cycle request) is wrong-path.
    if (flush)     kill_d = outst_next;
    else if (drop) kill_d = kill_q - OW'(1);

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_in)  fetch_pc_d = bus.redirect_pc_in;
    else if (pred_flush)  fetch_pc_d = bus.pred_target_in;
    else if (fire)        fetch_pc_d = next_seq_pc(fetch_pc_q);

    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != 8'hFF)) flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc_q  <= RESET_PC;
      kill_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Request-PC tags; its occupancy is the outstanding-request count.
  fetch_queue_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .clear_i     (1'b0),
    .push_i      (fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (resp),
    .pop_data_o  (tag_pc),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (outst)
  );

  fetch_queue_sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .clear_i     (flush),
    .push_i      (q_push),
    .push_data_i (push_entry),
    .pop_i       (q_pop),
    .pop_data_o  (head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign bus.imem_req_out  = req;
  assign bus.imem_addr_out = fetch_pc_q;
  assign bus.valid_out     = !q_empty;
  assign bus.pc_out        = head.pc;
  assign bus.instr_out     = head.instr;
  assign bus.flush_cnt_out = flush_cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model, head scoreboard and direct output checks.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.RESET_PC(64'h0), .DEPTH(4), .MAX_OUTST(2)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int hs_cnt = 0;
  logic mem_hold = 1'b0;
  logic [XLEN-1:0] exp_pc = '0;
  logic [XLEN+ILEN-1:0] exp_q [$];
  logic [XLEN-1:0] pend_q [$];

  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [XLEN-1:0] pc);
    bus.redirect_in    = 1'b1;
    bus.redirect_pc_in = pc;
    tick();
    bus.redirect_in    = 1'b0;
  endtask

  task automatic consume(input int n, output int cycles);
    int target;
    target = pops + n;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({exp_pc, instr_of(exp_pc)});
      exp_pc = exp_pc + 64'd4;
    end
    bus.ready_in = 1'b1;
    cycles = 0;
    while (pops < target && cycles < 60) begin
      tick();
      cycles++;
    end
    bus.ready_in = 1'b0;
    if (pops < target) begin
      tests++;
      fails++;
      $display("FAIL consume_timeout: got %0d pops expected %0d", n - (target - pops), n);
      exp_q.delete();
    end
  endtask

  // ---------------- memory model (in order, 1-cycle latency) ----------------
  initial begin
    bus.imem_valid_in = 1'b0;
    bus.imem_data_in  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_in) begin
        pend_q.delete();
        bus.imem_valid_in = 1'b0;
      end else begin
        if (bus.imem_valid_in && pend_q.size() > 0) void'(pend_q.pop_front());
        if (!mem_hold && pend_q.size() > 0) begin
          bus.imem_valid_in = 1'b1;
          bus.imem_data_in  = instr_of(pend_q[0]);
        end else begin
          bus.imem_valid_in = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_in && bus.imem_req_out && bus.imem_ready_in) begin
        pend_q.push_back(bus.imem_addr_out);
        hs_cnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [XLEN+ILEN-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_in && bus.valid_out && bus.ready_in && !bus.redirect_in) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got pc 0x%0h expected no pop", bus.pc_out);
        end else begin
          e = exp_q.pop_front();
          check64("head_pc", bus.pc_out, e[XLEN+ILEN-1:ILEN]);
          check64("head_instr", {32'b0, bus.instr_out}, {32'b0, e[ILEN-1:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int hs0;
    rst_in             = 1'b1;
    bus.imem_ready_in  = 1'b1;
    bus.ready_in       = 1'b0;
    bus.pred_taken_in  = 1'b0;
    bus.pred_target_in = '0;
    bus.redirect_in    = 1'b0;
    bus.redirect_pc_in = '0;
    repeat (2) tick();

    check64("rst_valid", {63'b0, bus.valid_out}, 64'd0);
    check64("rst_req", {63'b0, bus.imem_req_out}, 64'd0);
    check64("rst_addr", bus.imem_addr_out, 64'h0);
    check64("rst_pc_out", bus.pc_out, 64'h0);
    check64("rst_instr_out", {32'b0, bus.instr_out}, 64'h0);
    check64("rst_flush_cnt", {56'b0, bus.flush_cnt_out}, 64'd0);

    // Streaming from reset.
    rst_in = 1'b0;
    tick();
    check64("valid_1st_cycle", {63'b0, bus.valid_out}, 64'd0);
    tick();
    check64("valid_2nd_cycle", {63'b0, bus.valid_out}, 64'd1);
    check64("first_head_pc", bus.pc_out, 64'h0);
    consume(8, cyc);
    check64("stream_cycles", 64'(cyc), 64'd8);

    // Backpressure: queue fills to DEPTH, issue stops.
    hs0 = hs_cnt;
    repeat (6) tick();
    check64("bp_handshakes", 64'(hs_cnt - hs0), 64'd2);
    check64("bp_req_low", {63'b0, bus.imem_req_out}, 64'd0);
    check64("bp_fetch_pc", bus.imem_addr_out, 64'h30);
    check64("bp_head_pc", bus.pc_out, 64'h20);
    consume(8, cyc);

    // Redirect with two requests in flight.
    mem_hold = 1'b1;
    tick();
    check64("pre_redir_req", {63'b0, bus.imem_req_out}, 64'd0);
    do_redirect(64'h1000);
    mem_hold = 1'b0;
    check64("redir_flush_cnt", {56'b0, bus.flush_cnt_out}, 64'd1);
    check64("redir_valid", {63'b0, bus.valid_out}, 64'd0);
    check64("redir_req_blocked", {63'b0, bus.imem_req_out}, 64'd0);
    check64("redir_addr", bus.imem_addr_out, 64'h1000);
    exp_pc = 64'h1000;
    consume(4, cyc);

    // Taken prediction at head 0x20.
    do_redirect(64'h20);
    repeat (10) tick();
    check64("pred_head_valid", {63'b0, bus.valid_out}, 64'd1);
    check64("pred_head_pc", bus.pc_out, 64'h20);
    check64("pred_full_req", {63'b0, bus.imem_req_out}, 64'd0);
    exp_q.push_back({64'h20, instr_of(64'h20)});
    bus.ready_in       = 1'b1;
    bus.pred_taken_in  = 1'b1;
    bus.pred_target_in = 64'h80;
    tick();
    bus.ready_in      = 1'b0;
    bus.pred_taken_in = 1'b0;
    check64("pred_flush_cnt", {56'b0, bus.flush_cnt_out}, 64'd3);
    check64("pred_valid", {63'b0, bus.valid_out}, 64'd0);
    check64("pred_addr", bus.imem_addr_out, 64'h80);
    exp_pc = 64'h80;
    consume(3, cyc);

    // Redirect beats a same-cycle prediction.
    repeat (4) tick();
    bus.redirect_in    = 1'b1;
    bus.redirect_pc_in = 64'h200;
    bus.pred_taken_in  = 1'b1;
    bus.pred_target_in = 64'h80;
    bus.ready_in       = 1'b1;
    tick();
    bus.redirect_in   = 1'b0;
    bus.pred_taken_in = 1'b0;
    bus.ready_in      = 1'b0;
    check64("both_flush_cnt", {56'b0, bus.flush_cnt_out}, 64'd4);
    check64("both_addr", bus.imem_addr_out, 64'h200);
    exp_pc = 64'h200;
    consume(2, cyc);

    // Address held while memory stalls.
    bus.imem_ready_in = 1'b0;
    do_redirect(64'h300);
    check64("stall_addr_0", bus.imem_addr_out, 64'h300);
    tick();
    check64("stall_addr_1", bus.imem_addr_out, 64'h300);
    tick();
    check64("stall_addr_2", bus.imem_addr_out, 64'h300);
    check64("stall_req", {63'b0, bus.imem_req_out}, 64'd1);
    bus.imem_ready_in = 1'b1;
    exp_pc = 64'h300;
    consume(2, cyc);

    // 64-bit PC wrap.
    do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    check64("wrap_addr", bus.imem_addr_out, 64'hFFFF_FFFF_FFFF_FFF8);
    exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    consume(4, cyc);
    check64("wrap_flush_cnt", {56'b0, bus.flush_cnt_out}, 64'd6);

    // Flush counter saturation.
    repeat (248) do_redirect(64'h400);
    check64("flush_cnt_254", {56'b0, bus.flush_cnt_out}, 64'd254);
    do_redirect(64'h400);
    check64("flush_cnt_255", {56'b0, bus.flush_cnt_out}, 64'd255);
    repeat (3) do_redirect(64'h400);
    check64("flush_cnt_sat", {56'b0, bus.flush_cnt_out}, 64'd255);
    exp_pc = 64'h400;
    consume(2, cyc);

    // Asynchronous reset mid-operation.
    bus.ready_in = 1'b1;
    exp_q.push_back({64'h408, instr_of(64'h408)});
    #2;
    rst_in = 1'b1;
    bus.ready_in = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check64("mid_rst_flush_cnt", {56'b0, bus.flush_cnt_out}, 64'd0);
    check64("mid_rst_valid", {63'b0, bus.valid_out}, 64'd0);
    check64("mid_rst_req", {63'b0, bus.imem_req_out}, 64'd0);
    check64("mid_rst_addr", bus.imem_addr_out, 64'h0);
    repeat (2) tick();
    rst_in = 1'b0;
    check64("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
